// File: rtl/a2d_rr_sched.sv
// a2d_rr_sched
// Round-robin scheduler for the ADC128S converter. Each accepted nxt runs one
// two-transaction SPI exchange (the second transaction returns the conversion
// addressed by the first) and stores the 12-bit result for the current channel.
// Channel order: left load cell -> right load cell -> battery -> left ...
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   nxt      in   request next conversion (ignored while busy)
//   done     in   SPI master transaction complete pulse
//   rd_data  in   SPI master received word, [11:0] used
//   wrt      out  start SPI transaction pulse (registered)
//   cmd      out  SPI word {2'b00, chnl, 11'h000}
//   lft_ld   out  latest left load cell reading
//   rght_ld  out  latest right load cell reading
//   batt     out  latest battery reading
//   vld      out  pulse in the cycle after a result register was written
//   busy     out  high from accepted nxt until the capture cycle ends
//
// state | meaning
// IDLE  | waiting for nxt
// CNV   | first transaction in flight, its returned data is discarded
// GAP   | idle clocks between first done and second wrt
// RD    | second transaction in flight, returns the conversion
// CAP   | result register just written, vld high

module a2d_rr_sched #(
    parameter logic [2:0] LFT_CHNL  = 3'd0,
    parameter logic [2:0] RGHT_CHNL = 3'd4,
    parameter logic [2:0] BATT_CHNL = 3'd5,
    parameter int         GAP_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        vld,
    output logic        busy
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, CNV, GAP, RD, CAP} state_t;
    typedef enum logic [1:0] {RR_LFT, RR_RGHT, RR_BATT} rr_t;

    state_t        state, state_nxt;
    rr_t           rr_idx;
    logic [GW-1:0] gap_cnt;
    logic [2:0]    chnl;
    logic          wrt_nxt, vld_nxt, ld_cmd, gap_clr, gap_inc, capture;

    always_comb begin
        chnl = LFT_CHNL;
        case (rr_idx)
            RR_RGHT: chnl = RGHT_CHNL;
            RR_BATT: chnl = BATT_CHNL;
            default: chnl = LFT_CHNL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wrt_nxt   = 1'b0;
        vld_nxt   = 1'b0;
        ld_cmd    = 1'b0;
        gap_clr   = 1'b0;
        gap_inc   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (nxt) begin
                    state_nxt = CNV;
                    wrt_nxt   = 1'b1;
                    ld_cmd    = 1'b1;
                end
            end
            CNV: begin
                if (done) begin
                    state_nxt = GAP;
                    gap_clr   = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = RD;
                    wrt_nxt   = 1'b1;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            RD: begin
                // Result is written on the edge that leaves RD so that vld
                // in CAP coincides with the already-updated register.
                if (done) begin
                    state_nxt = CAP;
                    capture   = 1'b1;
                    vld_nxt   = 1'b1;
                end
            end
            CAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrt     <= 1'b0;
            vld     <= 1'b0;
            cmd     <= 16'h0000;
            gap_cnt <= '0;
            rr_idx  <= RR_LFT;
            lft_ld  <= 12'h000;
            rght_ld <= 12'h000;
            batt    <= 12'h000;
        end else begin
            wrt <= wrt_nxt;
            vld <= vld_nxt;
            if (ld_cmd) begin
                cmd <= {2'b00, chnl, 11'h000};
            end
            if (gap_clr) begin
                gap_cnt <= '0;
            end else if (gap_inc) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
            if (capture) begin
                case (rr_idx)
                    RR_RGHT: begin
                        rght_ld <= rd_data[11:0];
                        rr_idx  <= RR_BATT;
                    end
                    RR_BATT: begin
                        batt   <= rd_data[11:0];
                        rr_idx <= RR_LFT;
                    end
                    default: begin
                        lft_ld <= rd_data[11:0];
                        rr_idx <= RR_RGHT;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
